// File: rtl/ahb_lite_two_master_arbiter.sv
// ahb_lite_two_master_arbiter
// 2:1 AHB-Lite master multiplexer in front of a single AHB slave port.
// Master 0 is the PCIe-bridge master and master 1 is the local master.
// The address-phase owner is forwarded combinationally with no added latency.
// The bus is handed to the other master only when the owner shows an unlocked
// IDLE with HREADY high, so bursts and locked sequences are never split.
// Optional build macro ARB_STATS_EN adds per-master wait-cycle counters.
// These are saturating 16-bit counters with a stats_clr input.
module ahb_lite_two_master_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
`ifdef ARB_STATS_EN
    input  logic              stats_clr,
    output logic [15:0]       m0_wait_cnt,
    output logic [15:0]       m1_wait_cnt,
`endif
    input  logic [ADDR_W-1:0] m0_haddr,
    input  logic [1:0]        m0_htrans,
    input  logic              m0_hwrite,
    input  logic [2:0]        m0_hsize,
    input  logic [2:0]        m0_hburst,
    input  logic              m0_hmastlock,
    input  logic [DATA_W-1:0] m0_hwdata,
    output logic [DATA_W-1:0] m0_hrdata,
    output logic              m0_hready,
    output logic              m0_hresp,
    input  logic [ADDR_W-1:0] m1_haddr,
    input  logic [1:0]        m1_htrans,
    input  logic              m1_hwrite,
    input  logic [2:0]        m1_hsize,
    input  logic [2:0]        m1_hburst,
    input  logic              m1_hmastlock,
    input  logic [DATA_W-1:0] m1_hwdata,
    output logic [DATA_W-1:0] m1_hrdata,
    output logic              m1_hready,
    output logic              m1_hresp,
    output logic [ADDR_W-1:0] s_haddr,
    output logic [1:0]        s_htrans,
    output logic              s_hwrite,
    output logic [2:0]        s_hsize,
    output logic [2:0]        s_hburst,
    output logic              s_hmastlock,
    output logic [DATA_W-1:0] s_hwdata,
    input  logic              s_hready,
    input  logic [DATA_W-1:0] s_hrdata,
    input  logic              s_hresp,
    output logic              arb_owner
);

    logic owner_q, owner_d;
    logic dp_owner_q, dp_owner_d;
    logic dp_active_q, dp_active_d;

    logic       m0_req_s, m1_req_s;
    logic [1:0] fwd_htrans_s;
    logic       fwd_lock_s;
    logic       other_req_s;
    logic       handover_s;

    assign m0_req_s = m0_htrans[1];
    assign m1_req_s = m1_htrans[1];

    // Address-phase mux selected by the current owner; htrans/lock also feed arbitration.
    always_comb begin
        s_haddr      = m0_haddr;
        fwd_htrans_s = m0_htrans;
        s_hwrite     = m0_hwrite;
        s_hsize      = m0_hsize;
        s_hburst     = m0_hburst;
        fwd_lock_s   = m0_hmastlock;
        other_req_s  = m1_req_s;
        if (owner_q == 1'b1) begin
            s_haddr      = m1_haddr;
            fwd_htrans_s = m1_htrans;
            s_hwrite     = m1_hwrite;
            s_hsize      = m1_hsize;
            s_hburst     = m1_hburst;
            fwd_lock_s   = m1_hmastlock;
            other_req_s  = m0_req_s;
        end else begin
            other_req_s  = m1_req_s;
        end
    end

    // Handover only at an unlocked IDLE of the owner while the slave is ready.
    assign handover_s = s_hready && (fwd_htrans_s == 2'b00) && !fwd_lock_s && other_req_s;

    // Next-state for address-phase owner and data-phase tracking.
    always_comb begin
        owner_d     = owner_q;
        dp_owner_d  = dp_owner_q;
        dp_active_d = dp_active_q;
        if (handover_s) begin
            owner_d = ~owner_q;
        end else begin
            owner_d = owner_q;
        end
        if (s_hready) begin
            dp_owner_d  = owner_q;
            dp_active_d = fwd_htrans_s[1];
        end else begin
            dp_owner_d  = dp_owner_q;
            dp_active_d = dp_active_q;
        end
    end

    // Arbitration state registers with synchronous reset.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            owner_q     <= 1'b0;
            dp_owner_q  <= 1'b0;
            dp_active_q <= 1'b0;
        end else begin
            owner_q     <= owner_d;
            dp_owner_q  <= dp_owner_d;
            dp_active_q <= dp_active_d;
        end
    end

    // Write data follows the master that owns the data phase.
    assign s_hwdata  = dp_owner_q ? m1_hwdata : m0_hwdata;
    assign m0_hrdata = s_hrdata;
    assign m1_hrdata = s_hrdata;

    // Ready/response routing; the non-owner is stalled only while it requests.
    // A response is only passed on for a live data phase of that same master.
    always_comb begin
        s_htrans    = 2'b00;
        s_hmastlock = 1'b0;
        arb_owner   = 1'b0;
        m0_hready   = 1'b1;
        m1_hready   = 1'b1;
        m0_hresp    = 1'b0;
        m1_hresp    = 1'b0;
        if (reset_reset) begin
            s_htrans    = 2'b00;
            s_hmastlock = fwd_lock_s;
        end else begin
            s_htrans    = fwd_htrans_s;
            s_hmastlock = fwd_lock_s;
            arb_owner   = owner_q;
            if (owner_q == 1'b0) begin
                m0_hready = s_hready;
                m0_hresp  = s_hresp && dp_active_q && (dp_owner_q == 1'b0);
                m1_hready = ~m1_req_s;
                m1_hresp  = 1'b0;
            end else begin
                m1_hready = s_hready;
                m1_hresp  = s_hresp && dp_active_q && (dp_owner_q == 1'b1);
                m0_hready = ~m0_req_s;
                m0_hresp  = 1'b0;
            end
        end
    end

`ifdef ARB_STATS_EN
    logic [15:0] m0_wait_q, m0_wait_d;
    logic [15:0] m1_wait_q, m1_wait_d;

    // Saturating wait counters; clear wins over increment.
    always_comb begin
        m0_wait_d = m0_wait_q;
        m1_wait_d = m1_wait_q;
        if (stats_clr) begin
            m0_wait_d = 16'h0000;
            m1_wait_d = 16'h0000;
        end else begin
            if (m0_req_s && (owner_q != 1'b0) && (m0_wait_q != 16'hFFFF)) begin
                m0_wait_d = m0_wait_q + 16'h0001;
            end else begin
                m0_wait_d = m0_wait_q;
            end
            if (m1_req_s && (owner_q != 1'b1) && (m1_wait_q != 16'hFFFF)) begin
                m1_wait_d = m1_wait_q + 16'h0001;
            end else begin
                m1_wait_d = m1_wait_q;
            end
        end
    end

    // Wait counter registers.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            m0_wait_q <= 16'h0000;
            m1_wait_q <= 16'h0000;
        end else begin
            m0_wait_q <= m0_wait_d;
            m1_wait_q <= m1_wait_d;
        end
    end

    assign m0_wait_cnt = m0_wait_q;
    assign m1_wait_cnt = m1_wait_q;
`endif

endmodule

// File: tb/tb_ahb_lite_two_master_arbiter.sv
// Directed bench for ahb_lite_two_master_arbiter.
// Inputs change 1 ns after the rising edge; outputs are sampled 3 ns later.
module tb_ahb_lite_two_master_arbiter;

    logic        clk_clk = 1'b0;
    logic        reset_reset;
    logic [31:0] m0_haddr, m1_haddr, s_haddr;
    logic [1:0]  m0_htrans, m1_htrans, s_htrans;
    logic        m0_hwrite, m1_hwrite, s_hwrite;
    logic [2:0]  m0_hsize, m1_hsize, s_hsize;
    logic [2:0]  m0_hburst, m1_hburst, s_hburst;
    logic        m0_hmastlock, m1_hmastlock, s_hmastlock;
    logic [31:0] m0_hwdata, m1_hwdata, s_hwdata;
    logic [31:0] m0_hrdata, m1_hrdata, s_hrdata;
    logic        m0_hready, m1_hready, s_hready;
    logic        m0_hresp, m1_hresp, s_hresp;
    logic        arb_owner;
`ifdef ARB_STATS_EN
    logic        stats_clr;
    logic [15:0] m0_wait_cnt, m1_wait_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk_clk = ~clk_clk;

    ahb_lite_two_master_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset),
`ifdef ARB_STATS_EN
        .stats_clr(stats_clr), .m0_wait_cnt(m0_wait_cnt), .m1_wait_cnt(m1_wait_cnt),
`endif
        .m0_haddr(m0_haddr), .m0_htrans(m0_htrans), .m0_hwrite(m0_hwrite),
        .m0_hsize(m0_hsize), .m0_hburst(m0_hburst), .m0_hmastlock(m0_hmastlock),
        .m0_hwdata(m0_hwdata), .m0_hrdata(m0_hrdata), .m0_hready(m0_hready), .m0_hresp(m0_hresp),
        .m1_haddr(m1_haddr), .m1_htrans(m1_htrans), .m1_hwrite(m1_hwrite),
        .m1_hsize(m1_hsize), .m1_hburst(m1_hburst), .m1_hmastlock(m1_hmastlock),
        .m1_hwdata(m1_hwdata), .m1_hrdata(m1_hrdata), .m1_hready(m1_hready), .m1_hresp(m1_hresp),
        .s_haddr(s_haddr), .s_htrans(s_htrans), .s_hwrite(s_hwrite), .s_hsize(s_hsize),
        .s_hburst(s_hburst), .s_hmastlock(s_hmastlock), .s_hwdata(s_hwdata),
        .s_hready(s_hready), .s_hrdata(s_hrdata), .s_hresp(s_hresp), .arb_owner(arb_owner)
    );

    // Advance to just after the next rising edge.
    task automatic next_cycle();
        @(posedge clk_clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling.
    task automatic settle();
        #3;
    endtask

    task automatic set_m0(input logic [1:0] tr, input logic [31:0] a, input logic w,
                          input logic [2:0] b, input logic l);
        m0_htrans = tr; m0_haddr = a; m0_hwrite = w; m0_hburst = b; m0_hmastlock = l;
        m0_hsize = 3'b010;
    endtask

    task automatic set_m1(input logic [1:0] tr, input logic [31:0] a, input logic w,
                          input logic [2:0] b, input logic l);
        m1_htrans = tr; m1_haddr = a; m1_hwrite = w; m1_hburst = b; m1_hmastlock = l;
        m1_hsize = 3'b010;
    endtask

    task automatic test_reset();
        reset_reset = 1'b1;
        set_m0(2'b10, 32'h0000_0040, 1'b1, 3'b000, 1'b0);
        set_m1(2'b10, 32'h0000_0080, 1'b0, 3'b000, 1'b0);
        m0_hwdata = 32'h0; m1_hwdata = 32'h0;
        s_hready = 1'b0; s_hresp = 1'b1; s_hrdata = 32'h0;
`ifdef ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        next_cycle(); next_cycle(); settle();
        checks++; if (s_htrans !== 2'b00) begin errors++; $display("FAIL reset_htrans got %b want 00", s_htrans); end
        checks++; if ({m0_hready, m1_hready} !== 2'b11) begin errors++; $display("FAIL reset_hready got %b want 11", {m0_hready, m1_hready}); end
        checks++; if ({m0_hresp, m1_hresp} !== 2'b00) begin errors++; $display("FAIL reset_hresp got %b want 00", {m0_hresp, m1_hresp}); end
        checks++; if (arb_owner !== 1'b0) begin errors++; $display("FAIL reset_owner got %b want 0", arb_owner); end
        next_cycle();
        reset_reset = 1'b0;
        set_m0(2'b00, 32'h0, 1'b0, 3'b000, 1'b0);
        set_m1(2'b00, 32'h0, 1'b0, 3'b000, 1'b0);
        s_hready = 1'b1; s_hresp = 1'b0;
    endtask

    task automatic test_single_master();
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            set_m0(2'b10, 32'h100 + 32'(4 * i), 1'b1, 3'b000, 1'b0);
            m0_hwdata = 32'hA000 + 32'(i);
            settle();
            checks++; if (s_haddr !== 32'h100 + 32'(4 * i)) begin errors++; $display("FAIL single_addr beat%0d got %h want %h", i, s_haddr, 32'h100 + 32'(4 * i)); end
            checks++; if ({s_htrans, s_hwrite} !== 3'b101) begin errors++; $display("FAIL single_ctrl beat%0d got %b want 101", i, {s_htrans, s_hwrite}); end
            checks++; if ({m1_hready, m0_hready, arb_owner} !== 3'b110) begin errors++; $display("FAIL single_rdy_owner beat%0d got %b want 110", i, {m1_hready, m0_hready, arb_owner}); end
            checks++; if (s_hwdata !== 32'hA000 + 32'(i)) begin errors++; $display("FAIL single_wdata beat%0d got %h want %h", i, s_hwdata, 32'hA000 + 32'(i)); end
        end
        next_cycle();
        set_m0(2'b00, 32'h0, 1'b0, 3'b000, 1'b0);
    endtask

    task automatic test_handover();
        next_cycle();
        set_m1(2'b10, 32'h200, 1'b0, 3'b000, 1'b0);
        settle();
        checks++; if ({m1_hready, arb_owner, s_htrans} !== 4'b0000) begin errors++; $display("FAIL ho_t got rdy/own/tr %b want 0000", {m1_hready, arb_owner, s_htrans}); end
        next_cycle(); settle();
        checks++; if (arb_owner !== 1'b1) begin errors++; $display("FAIL ho_owner got %b want 1", arb_owner); end
        checks++; if (s_haddr !== 32'h200 || s_htrans !== 2'b10) begin errors++; $display("FAIL ho_addr got %h/%b want 200/10", s_haddr, s_htrans); end
        checks++; if ({m1_hready, m0_hready} !== 2'b11) begin errors++; $display("FAIL ho_rdy got %b want 11", {m1_hready, m0_hready}); end
`ifdef ARB_STATS_EN
        checks++; if (m1_wait_cnt !== 16'd1) begin errors++; $display("FAIL ho_wait_cnt got %0d want 1", m1_wait_cnt); end
`endif
        next_cycle();
        set_m1(2'b00, 32'h0, 1'b0, 3'b000, 1'b0);
        s_hrdata = 32'hDEAD_BEEF;
        settle();
        checks++; if (m1_hrdata !== 32'hDEAD_BEEF || m1_hready !== 1'b1) begin errors++; $display("FAIL ho_rdata got %h/%b want deadbeef/1", m1_hrdata, m1_hready); end
        checks++; if (arb_owner !== 1'b1) begin errors++; $display("FAIL ho_park got %b want 1", arb_owner); end
    endtask

    task automatic test_burst();
        next_cycle();
        set_m0(2'b10, 32'h300, 1'b1, 3'b011, 1'b0);
        m0_hwdata = 32'h0;
        settle();
        checks++; if ({m0_hready, arb_owner} !== 2'b01) begin errors++; $display("FAIL burst_pre got rdy/own %b want 01", {m0_hready, arb_owner}); end
        next_cycle();
        set_m1(2'b10, 32'h400, 1'b0, 3'b000, 1'b0);
        settle();
        checks++; if ({arb_owner, m0_hready, m1_hready} !== 3'b010 || s_haddr !== 32'h300) begin errors++; $display("FAIL burst_beat0 got own/r0/r1 %b addr %h want 010 300", {arb_owner, m0_hready, m1_hready}, s_haddr); end
        for (int i = 1; i < 4; i++) begin
            next_cycle();
            m0_hwdata = 32'h300 + 32'(4 * (i - 1));
            set_m0(2'b11, 32'h300 + 32'(4 * i), 1'b1, 3'b011, 1'b0);
            settle();
            checks++; if ({arb_owner, m1_hready, s_htrans} !== 4'b0011 || s_haddr !== 32'h300 + 32'(4 * i)) begin errors++; $display("FAIL burst_beat%0d got own/r1/tr %b addr %h", i, {arb_owner, m1_hready, s_htrans}, s_haddr); end
            checks++; if (s_hwdata !== 32'h300 + 32'(4 * (i - 1))) begin errors++; $display("FAIL burst_wdata%0d got %h", i, s_hwdata); end
        end
        next_cycle();
        set_m0(2'b00, 32'h0, 1'b0, 3'b000, 1'b0);
        settle();
        checks++; if ({arb_owner, m1_hready} !== 2'b00) begin errors++; $display("FAIL burst_idle got own/r1 %b want 00", {arb_owner, m1_hready}); end
        next_cycle(); settle();
        checks++; if ({arb_owner, m1_hready} !== 2'b11 || s_haddr !== 32'h400) begin errors++; $display("FAIL burst_after got own/r1 %b addr %h want 11 400", {arb_owner, m1_hready}, s_haddr); end
        next_cycle();
        set_m1(2'b00, 32'h0, 1'b0, 3'b000, 1'b0);
    endtask

    task automatic test_lock();
        next_cycle();
        set_m0(2'b10, 32'h500, 1'b1, 3'b000, 1'b1);
        next_cycle();
        set_m1(2'b10, 32'h600, 1'b0, 3'b000, 1'b0);
        settle();
        checks++; if ({arb_owner, m1_hready, s_hmastlock} !== 3'b001) begin errors++; $display("FAIL lock_first got own/r1/lk %b want 001", {arb_owner, m1_hready, s_hmastlock}); end
        next_cycle();
        set_m0(2'b00, 32'h500, 1'b0, 3'b000, 1'b1);
        settle();
        checks++; if ({arb_owner, m1_hready} !== 2'b00) begin errors++; $display("FAIL lock_idle got own/r1 %b want 00", {arb_owner, m1_hready}); end
        next_cycle();
        set_m0(2'b10, 32'h504, 1'b1, 3'b000, 1'b1);
        settle();
        checks++; if (arb_owner !== 1'b0 || s_haddr !== 32'h504) begin errors++; $display("FAIL lock_hold got own %b addr %h want 0 504", arb_owner, s_haddr); end
        next_cycle();
        set_m0(2'b00, 32'h0, 1'b0, 3'b000, 1'b0);
        settle();
        checks++; if (arb_owner !== 1'b0) begin errors++; $display("FAIL lock_release got own %b want 0", arb_owner); end
        next_cycle(); settle();
        checks++; if (arb_owner !== 1'b1 || s_haddr !== 32'h600 || s_hmastlock !== 1'b0) begin errors++; $display("FAIL lock_after got own %b addr %h lk %b want 1 600 0", arb_owner, s_haddr, s_hmastlock); end
        next_cycle();
        set_m1(2'b00, 32'h0, 1'b0, 3'b000, 1'b0);
    endtask

    task automatic test_wait_error();
        next_cycle();
        set_m1(2'b10, 32'h700, 1'b1, 3'b000, 1'b0);
        settle();
        checks++; if (arb_owner !== 1'b1) begin errors++; $display("FAIL err_owner got %b want 1", arb_owner); end
        next_cycle();
        set_m1(2'b00, 32'h0, 1'b0, 3'b000, 1'b0);
        set_m0(2'b10, 32'h800, 1'b0, 3'b000, 1'b0);
        s_hready = 1'b0; s_hresp = 1'b0;
        settle();
        checks++; if ({m1_hready, m0_hready, m1_hresp} !== 3'b000) begin errors++; $display("FAIL err_wait1 got r1/r0/e1 %b want 000", {m1_hready, m0_hready, m1_hresp}); end
        next_cycle(); settle();
        checks++; if (arb_owner !== 1'b1 || m1_hready !== 1'b0) begin errors++; $display("FAIL err_wait2 got own/r1 %b%b want 10", arb_owner, m1_hready); end
        next_cycle();
        s_hresp = 1'b1;
        settle();
        checks++; if ({m1_hready, m1_hresp, m0_hresp} !== 3'b010) begin errors++; $display("FAIL err_cyc1 got r1/e1/e0 %b want 010", {m1_hready, m1_hresp, m0_hresp}); end
        next_cycle();
        s_hready = 1'b1;
        settle();
        checks++; if ({m1_hready, m1_hresp, m0_hresp, m0_hready} !== 4'b1100) begin errors++; $display("FAIL err_cyc2 got r1/e1/e0/r0 %b want 1100", {m1_hready, m1_hresp, m0_hresp, m0_hready}); end
        next_cycle();
        s_hresp = 1'b0;
        settle();
        checks++; if (arb_owner !== 1'b0 || s_haddr !== 32'h800 || m0_hready !== 1'b1) begin errors++; $display("FAIL err_after got own %b addr %h r0 %b want 0 800 1", arb_owner, s_haddr, m0_hready); end
        next_cycle();
        set_m0(2'b00, 32'h0, 1'b0, 3'b000, 1'b0);
    endtask

    task automatic test_reset_mid_burst();
        next_cycle();
        set_m1(2'b10, 32'h900, 1'b0, 3'b011, 1'b0);
        next_cycle(); settle();
        checks++; if (arb_owner !== 1'b1) begin errors++; $display("FAIL rst_pre_owner got %b want 1", arb_owner); end
        next_cycle();
        set_m1(2'b11, 32'h904, 1'b0, 3'b011, 1'b0);
        reset_reset = 1'b1;
        settle();
        checks++; if ({arb_owner, s_htrans, m0_hready, m1_hready} !== 5'b00011) begin errors++; $display("FAIL rst_during got own/tr/r0/r1 %b want 00011", {arb_owner, s_htrans, m0_hready, m1_hready}); end
        next_cycle();
        reset_reset = 1'b0;
        set_m1(2'b00, 32'h0, 1'b0, 3'b000, 1'b0);
        settle();
        checks++; if ({arb_owner, s_htrans, m0_hready, m1_hready} !== 5'b00011) begin errors++; $display("FAIL rst_after got own/tr/r0/r1 %b want 00011", {arb_owner, s_htrans, m0_hready, m1_hready}); end
`ifdef ARB_STATS_EN
        checks++; if ({m0_wait_cnt, m1_wait_cnt} !== 32'h0) begin errors++; $display("FAIL rst_cnt got %0d/%0d want 0/0", m0_wait_cnt, m1_wait_cnt); end
`endif
    endtask

    initial begin
        test_reset();
        test_single_master();
        test_handover();
        test_burst();
        test_lock();
        test_wait_error();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
